// File: rtl/mem_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types and constants for the memory bus responder:
//                FSM state encoding, data width and error read pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int                DATA_W   = 16;
    localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        WAIT    = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } state_t;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_bus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_if
//  Description : CPU memory request bus. The CPU side is the master; the
//                memory responder is the slave. bus_err exists only when
//                MEM_BUS_ERR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_if;
    import mem_bus_pkg::*;

    logic              MREQ_N;
    logic              R_W_N;
    logic [15:0]       m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_bus;
    logic              MACK_N;
    logic              busy;
`ifdef MEM_BUS_ERR_EN
    logic              bus_err;
`endif

    modport master (
        output MREQ_N, R_W_N, m_addr, m_wdata,
`ifdef MEM_BUS_ERR_EN
        input  bus_err,
`endif
        input  m_bus, MACK_N, busy
    );

    modport slave (
        input  MREQ_N, R_W_N, m_addr, m_wdata,
`ifdef MEM_BUS_ERR_EN
        output bus_err,
`endif
        output m_bus, MACK_N, busy
    );

endinterface : mem_bus_if
`default_nettype wire

// File: rtl/mem_bus_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ram_sp
//  Description : Single-port synchronous RAM, DATA_W x 2**ADDR_W words, with
//                write enable and registered read. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ram_sp
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic              re_i,
    input  wire logic [ADDR_W-1:0] addr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic      [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port; the read register only moves on re_i
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_ram_sp
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_responder
//  Description : Memory-side responder for the CPU request bus. Accepts a
//                request, performs the RAM access, inserts WAIT_CYCLES wait
//                states and answers with a one-cycle MACK_N pulse.
//                Optional macro MEM_BUS_ERR_EN: out-of-range addresses
//                (m_addr[15:ADDR_W] != 0) are not written, read as ERR_DATA
//                and raise bus_err during ACK. Undefined: addresses alias.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic CLK,
    input  wire logic CLR,
    mem_bus_if.slave  bus
);

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic                rw_q,    rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q,   cnt_d;
    logic                viol_q,  viol_d;   // request dropped during WAIT
    logic                err_q,   err_d;    // out-of-range access
    logic [DATA_W-1:0]   mbus_q,  mbus_d;   // last read data, held between reads

    logic                w_ram_we;
    logic                w_ram_re;
    logic [DATA_W-1:0]   w_ram_rdata;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_err_addr;

`ifdef MEM_BUS_ERR_EN
    assign w_err_addr = |bus.m_addr[15:ADDR_W];
    assign w_rdata    = err_q ? ERR_DATA : w_ram_rdata;
    assign bus.bus_err = (state_q == ACK) && err_q;
`else
    // Upper address bits are deliberately ignored so the address space aliases
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^bus.m_addr[15:ADDR_W];
    assign w_err_addr = 1'b0;
    assign w_rdata    = w_ram_rdata;
`endif

    // State and transaction registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            viol_q  <= 1'b0;
            err_q   <= 1'b0;
            mbus_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            viol_q  <= viol_d;
            err_q   <= err_d;
            mbus_q  <= mbus_d;
        end
    end

    // Next-state logic and RAM strobes
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        viol_d   = viol_q;
        err_d    = err_q;
        mbus_d   = mbus_q;
        w_ram_we = 1'b0;
        w_ram_re = 1'b0;

        case (state_q)
            IDLE: begin
                viol_d = 1'b0;
                if (!bus.MREQ_N) begin
                    addr_d  = bus.m_addr[ADDR_W-1:0];
                    rw_d    = bus.R_W_N;
                    wdata_d = bus.m_wdata;
                    err_d   = w_err_addr;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                w_ram_we = !rw_q && !err_q;
                w_ram_re = rw_q;
                cnt_d    = c_WAIT;
                state_d  = (c_WAIT != 4'd0) ? WAIT : ACK;
            end
            WAIT: begin
                if (bus.MREQ_N) begin
                    viol_d = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (rw_q) begin
                    mbus_d = w_rdata;
                end
                // A request dropped early needs no release handshake
                state_d = viol_q ? IDLE : RELEASE;
            end
            RELEASE: begin
                if (bus.MREQ_N) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.MACK_N = (state_q != ACK);
    assign bus.busy   = (state_q == ACCEPT) || (state_q == WAIT) || (state_q == ACK);
    // Fresh read data appears during ACK itself; otherwise the held value
    assign bus.m_bus  = ((state_q == ACK) && rw_q) ? w_rdata : mbus_q;

    mem_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (CLK),
        .we_i    (w_ram_we),
        .re_i    (w_ram_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (w_ram_rdata)
    );

endmodule : mem_bus_responder
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_responder
//  Description : Directed self-checking bench. Two responders (WAIT_CYCLES
//                = 2 and 0) share one request stream and so hold identical
//                RAM contents. Latency k counts rising edges after the
//                acceptance edge N; MACK_N low in cycle N+2+W is first seen
//                after edge N+1+W, i.e. k = W+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;
    import mem_bus_pkg::*;

    logic        clk;
    logic        clr;
    logic        mreq_n;
    logic        r_w_n;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;

    int checks = 0;
    int errors = 0;

    mem_bus_if bus2 ();
    mem_bus_if bus0 ();

    assign bus2.MREQ_N  = mreq_n;
    assign bus2.R_W_N   = r_w_n;
    assign bus2.m_addr  = m_addr;
    assign bus2.m_wdata = m_wdata;
    assign bus0.MREQ_N  = mreq_n;
    assign bus0.R_W_N   = r_w_n;
    assign bus0.m_addr  = m_addr;
    assign bus0.m_wdata = m_wdata;

    mem_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .CLK (clk), .CLR (clr), .bus (bus2.slave)
    );
    mem_bus_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .CLK (clk), .CLR (clr), .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the most recent transaction
    int          lat2, lat0, p2, p0, perr;
    logic [15:0] d2, d0;
    logic        acc_busy2, acc_busy0;
    state_t      hist2 [0:15];

    // One request: drop_k > 0 raises MREQ_N after edge drop_k regardless of
    // ACK; otherwise MREQ_N is held until both ACKs are seen and k >= hold_k.
    task automatic xfer(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                        input int drop_k, input int hold_k);
        lat2 = 0; lat0 = 0; p2 = 0; p0 = 0; perr = 0; d2 = '0; d0 = '0;
        for (int i = 0; i < 16; i++) hist2[i] = IDLE;
        r_w_n = rw; m_addr = addr; m_wdata = wdata; mreq_n = 1'b0;
        @(posedge clk); #1;
        acc_busy2 = bus2.busy;
        acc_busy0 = bus0.busy;
        // Scramble the request fields; they must be ignored from here on
        r_w_n = ~rw; m_addr = ~addr; m_wdata = ~wdata;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            hist2[k] = dut2.state_q;
            if (!bus2.MACK_N) begin
                p2++;
                if (lat2 == 0) begin lat2 = k; d2 = bus2.m_bus; end
            end
            if (!bus0.MACK_N) begin
                p0++;
                if (lat0 == 0) begin lat0 = k; d0 = bus0.m_bus; end
            end
`ifdef MEM_BUS_ERR_EN
            if (bus2.bus_err) perr++;
`endif
            if ((drop_k > 0 && k == drop_k) ||
                (drop_k == 0 && lat2 != 0 && lat0 != 0 && k >= hold_k))
                mreq_n = 1'b1;
        end
        mreq_n = 1'b1;
        checks++;
        if (lat2 == 0 || lat0 == 0) begin
            errors++;
            $display("FAIL ack_timeout: lat2=%0d lat0=%0d, required both nonzero", lat2, lat0);
        end
    endtask

    task automatic test_reset;
        clr = 1'b0; mreq_n = 1'b1; r_w_n = 1'b1; m_addr = '0; m_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus2.MACK_N !== 1'b1) begin errors++; $display("FAIL reset_mack: got %b required 1", bus2.MACK_N); end
        checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus2.busy); end
        checks++; if (bus2.m_bus !== 16'h0000) begin errors++; $display("FAIL reset_mbus: got %h required 0000", bus2.m_bus); end
        checks++; if (bus0.MACK_N !== 1'b1) begin errors++; $display("FAIL reset_mack0: got %b required 1", bus0.MACK_N); end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        xfer(1'b0, 16'h0004, 16'hA5C3, 0, 0);
        checks++; if (acc_busy2 !== 1'b1) begin errors++; $display("FAIL wr_busy_accept: got %b required 1", acc_busy2); end
        checks++; if (lat2 !== 3) begin errors++; $display("FAIL wr_latency_w2: got %0d required 3", lat2); end
        checks++; if (d2 !== 16'h0000) begin errors++; $display("FAIL wr_mbus_unchanged: got %h required 0000", d2); end
        xfer(1'b1, 16'h0004, 16'h0000, 0, 0);
        checks++; if (lat2 !== 3) begin errors++; $display("FAIL rd_latency_w2: got %0d required 3", lat2); end
        checks++; if (d2 !== 16'hA5C3) begin errors++; $display("FAIL rd_data_w2: got %h required a5c3", d2); end
        checks++; if (p2 !== 1) begin errors++; $display("FAIL rd_pulses_w2: got %0d required 1", p2); end
        checks++; if (bus2.m_bus !== 16'hA5C3) begin errors++; $display("FAIL rd_mbus_hold: got %h required a5c3", bus2.m_bus); end
        checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_idle: got %b required 0", bus2.busy); end
    endtask

    task automatic test_zero_wait;
        xfer(1'b0, 16'h0010, 16'h1234, 0, 0);
        checks++; if (lat0 !== 1) begin errors++; $display("FAIL zw_wr_latency: got %0d required 1", lat0); end
        checks++; if (d0 !== 16'hA5C3) begin errors++; $display("FAIL zw_wr_mbus_keep: got %h required a5c3", d0); end
        xfer(1'b1, 16'h0010, 16'h0000, 0, 0);
        checks++; if (acc_busy0 !== 1'b1) begin errors++; $display("FAIL zw_busy_accept: got %b required 1", acc_busy0); end
        checks++; if (lat0 !== 1) begin errors++; $display("FAIL zw_rd_latency: got %0d required 1", lat0); end
        checks++; if (d0 !== 16'h1234) begin errors++; $display("FAIL zw_rd_data: got %h required 1234", d0); end
        checks++; if (d2 !== 16'h1234) begin errors++; $display("FAIL zw_rd_data_w2: got %h required 1234", d2); end
    endtask

    task automatic test_held;
        xfer(1'b1, 16'h0004, 16'h0000, 0, 10);
        checks++; if (p2 !== 1) begin errors++; $display("FAIL held_pulses_w2: got %0d required 1", p2); end
        checks++; if (p0 !== 1) begin errors++; $display("FAIL held_pulses_w0: got %0d required 1", p0); end
        checks++; if (hist2[10] !== RELEASE) begin errors++; $display("FAIL held_in_release: got %0d required %0d", hist2[10], RELEASE); end
        checks++; if (hist2[11] !== IDLE) begin errors++; $display("FAIL held_to_idle: got %0d required %0d", hist2[11], IDLE); end
        checks++; if (d2 !== 16'hA5C3) begin errors++; $display("FAIL held_data: got %h required a5c3", d2); end
    endtask

    task automatic test_violation;
        xfer(1'b0, 16'h0020, 16'h0BEE, 1, 0);
        checks++; if (lat2 !== 3) begin errors++; $display("FAIL viol_latency: got %0d required 3", lat2); end
        checks++; if (p2 !== 1) begin errors++; $display("FAIL viol_pulses: got %0d required 1", p2); end
        checks++; if (hist2[4] !== IDLE) begin errors++; $display("FAIL viol_direct_idle: got %0d required %0d", hist2[4], IDLE); end
        xfer(1'b1, 16'h0020, 16'h0000, 0, 0);
        checks++; if (d2 !== 16'h0BEE) begin errors++; $display("FAIL viol_write_done: got %h required 0bee", d2); end
        checks++; if (hist2[4] !== RELEASE) begin errors++; $display("FAIL normal_release: got %0d required %0d", hist2[4], RELEASE); end
    endtask

    task automatic test_alias;
        logic [15:0] exp_w0;
        logic [15:0] exp_hi;
`ifdef MEM_BUS_ERR_EN
        exp_w0 = 16'h5555;
        exp_hi = 16'hFFFF;
`else
        exp_w0 = 16'h0F0F;
        exp_hi = 16'h0F0F;
`endif
        xfer(1'b0, 16'h0000, 16'h5555, 0, 0);
        xfer(1'b0, 16'h0400, 16'h0F0F, 0, 0);
        xfer(1'b1, 16'h0000, 16'h0000, 0, 0);
        checks++; if (d2 !== exp_w0) begin errors++; $display("FAIL alias_word0: got %h required %h", d2, exp_w0); end
        xfer(1'b1, 16'h0400, 16'h0000, 0, 0);
        checks++; if (d2 !== exp_hi) begin errors++; $display("FAIL alias_hi_read: got %h required %h", d2, exp_hi); end
        checks++; if (d0 !== exp_hi) begin errors++; $display("FAIL alias_hi_read_w0: got %h required %h", d0, exp_hi); end
`ifdef MEM_BUS_ERR_EN
        checks++; if (perr !== 1) begin errors++; $display("FAIL err_pulse: got %0d required 1", perr); end
        xfer(1'b1, 16'h0000, 16'h0000, 0, 0);
        checks++; if (perr !== 0) begin errors++; $display("FAIL err_none_inrange: got %0d required 0", perr); end
`endif
    endtask

    task automatic test_reset_mid_wait;
        r_w_n = 1'b1; m_addr = 16'h0004; mreq_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus2.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b required 1", bus2.busy); end
        #2 clr = 1'b0;
        #1;
        checks++; if (bus2.MACK_N !== 1'b1) begin errors++; $display("FAIL rst_mid_mack: got %b required 1", bus2.MACK_N); end
        checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", bus2.busy); end
        checks++; if (bus2.m_bus !== 16'h0000) begin errors++; $display("FAIL rst_mid_mbus: got %h required 0000", bus2.m_bus); end
        mreq_n = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        xfer(1'b1, 16'h0004, 16'h0000, 0, 0);
        checks++; if (lat2 !== 3) begin errors++; $display("FAIL rst_after_latency: got %0d required 3", lat2); end
        checks++; if (d2 !== 16'hA5C3) begin errors++; $display("FAIL rst_after_data: got %h required a5c3", d2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_held();
        test_violation();
        test_alias();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_bus_responder
`default_nettype wire
